// File: rtl/button_event_capture.sv
// Pushbutton conditioning for host observation: synchronise, debounce, detect
// presses, keep sticky flags plus a shared press counter, and pack a status word.
module button_event_capture #(
  parameter int N_BUTTONS       = 4,
  parameter int DEBOUNCE_CYCLES = 48000,
  parameter int CNT_WIDTH       = 8
) (
  input  logic                 ti_clk,
  input  logic                 reset,
  input  logic [N_BUTTONS-1:0] button,
  input  logic                 clear,
  output logic [15:0]          status,
  output logic [N_BUTTONS-1:0] press_pulse
);

  localparam int DCNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_BUTTONS-1:0]             meta_q, sync_q;
  logic [N_BUTTONS-1:0]             sync_pressed;
  logic [N_BUTTONS-1:0]             deb_q, deb_d;
  logic [N_BUTTONS-1:0]             deb_dly_q;
  logic [N_BUTTONS-1:0][DCNT_W-1:0] dcnt_q, dcnt_d;
  logic [N_BUTTONS-1:0]             press;
  logic [N_BUTTONS-1:0]             flag_q, flag_d;
  logic [CNT_WIDTH-1:0]             cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]             press_count;
  logic [15:0]                      status_q, status_d;
  logic [N_BUTTONS-1:0]             pulse_q;

  // Buttons are active-low on the board; internally 1 means pressed.
  assign sync_pressed = ~sync_q;

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    deb_d  = deb_q;
    dcnt_d = dcnt_q;
    for (int i = 0; i < N_BUTTONS; i++) begin
      if (sync_pressed[i] == deb_q[i]) begin
        dcnt_d[i] = '0;
      end else if (dcnt_q[i] == DCNT_LAST) begin
        deb_d[i]  = ~deb_q[i];
        dcnt_d[i] = '0;
      end else begin
        dcnt_d[i] = dcnt_q[i] + DCNT_W'(1);
      end
    end
  end

  // A press in the same cycle as clear survives; the counter wraps freely.
  always_comb begin
    press       = deb_q & ~deb_dly_q;
    flag_d      = (clear ? '0 : flag_q) | press;
    press_count = '0;
    for (int i = 0; i < N_BUTTONS; i++) begin
      press_count = press_count + CNT_WIDTH'(press[i]);
    end
    cnt_d = (clear ? '0 : cnt_q) + press_count;
  end

  always_comb begin
    status_d                  = '0;
    status_d[N_BUTTONS-1:0]   = deb_q;
    status_d[4 +: N_BUTTONS]  = flag_d;
    status_d[8 +: CNT_WIDTH]  = cnt_d;
  end

  // NOTE: state uses non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge ti_clk or posedge reset) begin
    if (reset) begin
      meta_q    <= '1;
      sync_q    <= '1;
      deb_q     <= '0;
      deb_dly_q <= '0;
      dcnt_q    <= '0;
      flag_q    <= '0;
      cnt_q     <= '0;
      status_q  <= '0;
      pulse_q   <= '0;
    end else begin
      meta_q    <= button;
      sync_q    <= meta_q;
      deb_q     <= deb_d;
      deb_dly_q <= deb_q;
      dcnt_q    <= dcnt_d;
      flag_q    <= flag_d;
      cnt_q     <= cnt_d;
      status_q  <= status_d;
      pulse_q   <= press;
    end
  end

  assign status      = status_q;
  assign press_pulse = pulse_q;

endmodule

// File: tb/tb_button_event_capture.sv
// Directed bench for button_event_capture with DEBOUNCE_CYCLES=4, CNT_WIDTH=8.
module tb_button_event_capture;

  logic        ti_clk = 1'b0;
  logic        reset;
  logic [3:0]  button;
  logic        clear;
  logic [15:0] status;
  logic [3:0]  press_pulse;

  int checks = 0;
  int errors = 0;

  button_event_capture #(
    .N_BUTTONS      (4),
    .DEBOUNCE_CYCLES(4),
    .CNT_WIDTH      (8)
  ) dut (
    .ti_clk     (ti_clk),
    .reset      (reset),
    .button     (button),
    .clear      (clear),
    .status     (status),
    .press_pulse(press_pulse)
  );

  always #5 ti_clk = ~ti_clk;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge ti_clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
  endtask

  task automatic press_release(input int idx);
    button[idx] = 1'b0;
    tick(8);
    button[idx] = 1'b1;
    tick(8);
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    button = 4'hF;
    clear  = 1'b0;
    #12;
    checks++;
    if (status !== 16'h0000) begin
      errors++;
      $display("FAIL reset_status: got %h want 0000", status);
    end
    checks++;
    if (press_pulse !== 4'h0) begin
      errors++;
      $display("FAIL reset_pulse: got %h want 0", press_pulse);
    end
    @(posedge ti_clk);
    #1 reset = 1'b0;
    for (int j = 0; j < 10; j++) begin
      tick(1);
      checks++;
      if (status !== 16'h0000 || press_pulse !== 4'h0) begin
        errors++;
        $display("FAIL idle_after_reset: cycle %0d got status %h pulse %h want 0000/0", j, status, press_pulse);
      end
    end
  endtask

  task automatic test_single_press();
    button[0] = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      tick(1);
      checks++;
      if (press_pulse !== ((j == 7) ? 4'h1 : 4'h0)) begin
        errors++;
        $display("FAIL single_pulse: edge k+%0d got %h want %h", j, press_pulse, (j == 7) ? 4'h1 : 4'h0);
      end
      if (j == 6 || j == 7) begin
        checks++;
        if (status !== ((j == 7) ? 16'h0111 : 16'h0000)) begin
          errors++;
          $display("FAIL single_status: edge k+%0d got %h want %h", j, status, (j == 7) ? 16'h0111 : 16'h0000);
        end
      end
    end
    tick(12);
    button[0] = 1'b1;
    for (int j = 21; j <= 30; j++) begin
      tick(1);
      checks++;
      if (press_pulse !== 4'h0) begin
        errors++;
        $display("FAIL release_pulse: edge k+%0d got %h want 0", j, press_pulse);
      end
      if (j == 26 || j == 27) begin
        checks++;
        if (status !== ((j == 27) ? 16'h0110 : 16'h0111)) begin
          errors++;
          $display("FAIL release_status: edge k+%0d got %h want %h", j, status, (j == 27) ? 16'h0110 : 16'h0111);
        end
      end
    end
  endtask

  task automatic test_bounce();
    logic [16:0] pattern;
    int          pulses;
    pattern = 17'b1111111111_000_1_000;
    do_clear();
    checks++;
    if (status !== 16'h0000) begin
      errors++;
      $display("FAIL bounce_start: got %h want 0000", status);
    end
    for (int j = 0; j < 17; j++) begin
      button[1] = pattern[j];
      tick(1);
      checks++;
      if (press_pulse !== 4'h0) begin
        errors++;
        $display("FAIL bounce_pulse: step %0d got %h want 0", j, press_pulse);
      end
    end
    checks++;
    if (status !== 16'h0000) begin
      errors++;
      $display("FAIL bounce_status: got %h want 0000", status);
    end
    pulses = 0;
    button[1] = 1'b0;
    for (int j = 0; j < 12; j++) begin
      tick(1);
      if (press_pulse == 4'h2) pulses++;
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL held_press_count: got %0d pulses want 1", pulses);
    end
    checks++;
    if (status !== 16'h0122) begin
      errors++;
      $display("FAIL held_status: got %h want 0122", status);
    end
    button[1] = 1'b1;
    tick(10);
    checks++;
    if (status !== 16'h0120) begin
      errors++;
      $display("FAIL held_release_status: got %h want 0120", status);
    end
  endtask

  task automatic test_simultaneous();
    do_clear();
    button = 4'h0;
    for (int j = 1; j <= 10; j++) begin
      tick(1);
      checks++;
      if (press_pulse !== ((j == 7) ? 4'hF : 4'h0)) begin
        errors++;
        $display("FAIL simul_pulse: edge k+%0d got %h want %h", j, press_pulse, (j == 7) ? 4'hF : 4'h0);
      end
      if (j == 7) begin
        checks++;
        if (status !== 16'h04FF) begin
          errors++;
          $display("FAIL simul_status: got %h want 04FF", status);
        end
      end
    end
    button = 4'hF;
    tick(10);
    checks++;
    if (status !== 16'h04F0) begin
      errors++;
      $display("FAIL simul_release_status: got %h want 04F0", status);
    end
  endtask

  task automatic test_wrap();
    do_clear();
    for (int p = 0; p < 256; p++) begin
      press_release(2);
      if (p == 254) begin
        checks++;
        if (status !== 16'hFF40) begin
          errors++;
          $display("FAIL wrap_255: got %h want FF40", status);
        end
      end
    end
    checks++;
    if (status !== 16'h0040) begin
      errors++;
      $display("FAIL wrap_256: got %h want 0040", status);
    end
  endtask

  task automatic test_clear_press();
    do_clear();
    press_release(1);
    press_release(1);
    press_release(1);
    press_release(2);
    press_release(2);
    checks++;
    if (status !== 16'h0560) begin
      errors++;
      $display("FAIL clear_setup: got %h want 0560", status);
    end
    button[0] = 1'b0;
    tick(6);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    checks++;
    if (press_pulse !== 4'h1) begin
      errors++;
      $display("FAIL clear_press_pulse: got %h want 1", press_pulse);
    end
    checks++;
    if (status !== 16'h0111) begin
      errors++;
      $display("FAIL clear_press_status: got %h want 0111", status);
    end
    clear = 1'b1;
    tick(3);
    clear = 1'b0;
    checks++;
    if (status !== 16'h0001) begin
      errors++;
      $display("FAIL clear_hold_status: got %h want 0001", status);
    end
  endtask

  task automatic test_async_reset();
    @(negedge ti_clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (status !== 16'h0000 || press_pulse !== 4'h0) begin
      errors++;
      $display("FAIL async_reset: got status %h pulse %h want 0000/0", status, press_pulse);
    end
    tick(2);
    reset = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      tick(1);
      checks++;
      if (press_pulse !== ((j == 7) ? 4'h1 : 4'h0)) begin
        errors++;
        $display("FAIL requalify_pulse: edge m+%0d got %h want %h", j, press_pulse, (j == 7) ? 4'h1 : 4'h0);
      end
      if (j == 6 || j == 7) begin
        checks++;
        if (status !== ((j == 7) ? 16'h0111 : 16'h0000)) begin
          errors++;
          $display("FAIL requalify_status: edge m+%0d got %h want %h", j, status, (j == 7) ? 16'h0111 : 16'h0000);
        end
      end
    end
    button = 4'hF;
    tick(10);
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_simultaneous();
    test_wrap();
    test_clear_press();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
